// File: rtl/word_serializer_pkg.sv
// rtl/word_serializer_pkg.sv - shared types and sizing helpers for word_serializer
//
// Purpose : FSM state encoding and counter-width helper used by word_serializer.
// Contents: ser_state_e - IDLE / SHIFT / PARITY / GAP
//           cnt_w(n)    - bits needed to hold 0..n, never less than 1

package word_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } ser_state_e;

  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - parallel-to-serial front end for the serial shift-register stage
//
// Purpose : accepts one WIDTH-bit word per valid/ready handshake and emits it one
//           bit per cycle on out_bit, qualified by out_en. Optional trailing
//           even-parity beat and GAP idle cycles after every word.
// Macro   : WORD_SERIALIZER_PARITY_EN - when defined, a PARITY beat follows the data beats.
// Ports   : clk      - clock, all state on posedge
//           rstn     - asynchronous reset, active-low
//           in_valid - upstream word valid
//           in_ready - block can accept a word (IDLE only)
//           in_data  - word, sampled on handshake
//           out_en   - serial beat valid / downstream shift enable
//           out_bit  - serial data bit (0 whenever out_en=0)
//           busy     - word in flight (SHIFT, PARITY or GAP)
//           done     - one-cycle pulse on the final beat of a word

module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_en,
  output logic             out_bit,
  output logic             busy,
  output logic             done
);

  localparam int BW = cnt_w(WIDTH);
  localparam int GW = cnt_w(GAP);

  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);
  // Index of the beat just before the last one; only meaningful when WIDTH > 1.
  localparam logic [BW-1:0] PENULT   = BW'((WIDTH > 1) ? (WIDTH - 2) : 0);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP);

`ifdef WORD_SERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  ser_state_e       state;
  logic [WIDTH-1:0] sh;        // shadow word, shifted so the next bit is always at the exit end
  logic [BW-1:0]    bit_cnt;   // index of the beat currently on out_bit
  logic [GW-1:0]    gap_cnt;   // gap cycles already spent, 1..GAP
`ifdef WORD_SERIALIZER_PARITY_EN
  logic             par_bit;   // even parity of the whole word, captured at handshake
`endif

  logic finishing;

  // The cycle on which the final beat is showing; the next edge closes the word.
  assign finishing = ((state == SHIFT) && (bit_cnt == LAST_IDX) && !PAR_EN) ||
                     (state == PARITY);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      sh       <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      in_ready <= 1'b0;
      out_en   <= 1'b0;
      out_bit  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else if (finishing) begin
      out_en  <= 1'b0;
      out_bit <= 1'b0;
      done    <= 1'b0;
      if (GAP > 0) begin
        state   <= word_serializer_pkg::GAP;
        gap_cnt <= GW'(1);
      end else begin
        state    <= IDLE;
        busy     <= 1'b0;
        in_ready <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            // Beat 0 goes out straight from in_data; sh keeps the remaining bits.
            sh       <= LSB_FIRST ? (in_data >> 1) : (in_data << 1);
            out_bit  <= LSB_FIRST ? in_data[0] : in_data[WIDTH-1];
`ifdef WORD_SERIALIZER_PARITY_EN
            par_bit  <= ^in_data;
`endif
            bit_cnt  <= '0;
            out_en   <= 1'b1;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            done     <= !PAR_EN && (WIDTH == 1);
            state    <= SHIFT;
          end else begin
            in_ready <= 1'b1;
          end
        end

        SHIFT: begin
          if (bit_cnt == LAST_IDX) begin
`ifdef WORD_SERIALIZER_PARITY_EN
            out_bit <= par_bit;
            done    <= 1'b1;
            state   <= PARITY;
`endif
          end else begin
            out_bit <= LSB_FIRST ? sh[0] : sh[WIDTH-1];
            sh      <= LSB_FIRST ? (sh >> 1) : (sh << 1);
            bit_cnt <= bit_cnt + 1'b1;
            done    <= !PAR_EN && (bit_cnt == PENULT);
          end
        end

        word_serializer_pkg::GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
